// File: rtl/branch_predict_unit.sv
// Branch resolver plus 2-bit saturating BHT: lookup combinational, resolve/update/stats one cycle later.
// No backpressure: one execute-stage instruction is accepted every cycle that e_valid is high.
module branch_predict_unit #(
  parameter int         WIDTH      = 32,
  parameter int         BHT_DEPTH  = 16,
  parameter logic [1:0] INIT_STATE = 2'd1,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] f_pc,
  output logic             f_predTaken,
  input  logic             e_valid,
  input  logic [WIDTH-1:0] e_pc,
  input  logic             isBeq,
  input  logic             isBgt,
  input  logic             isUBranch,
  input  logic             isRet,
  input  logic             flagsE,
  input  logic             flagsGT,
  input  logic [WIDTH-1:0] branchTarget,
  input  logic [WIDTH-1:0] op1,
  input  logic             e_predTaken,
  output logic             isBranchTaken,
  output logic [WIDTH-1:0] branchPC,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirectPC,
  output logic [CNT_W-1:0] branchCount,
  output logic [CNT_W-1:0] mispredictCount
);

  localparam int IDX = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX-1:0]   fIdx;
  logic [IDX-1:0]   eIdx;
  logic             anyBranch;
  logic             taken;
  logic             isMiss;
  logic             condUpdate;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] nextPC;
  logic             unusedPcBits;

  assign fIdx         = f_pc[IDX+1:2];
  assign eIdx         = e_pc[IDX+1:2];
  assign unusedPcBits = ^{f_pc[WIDTH-1:IDX+2], f_pc[1:0]};

  // No bypass: a same-cycle update is only visible after the edge.
  assign f_predTaken = bht[fIdx][1];

  assign anyBranch  = isBeq | isBgt | isUBranch | isRet;
  assign taken      = isUBranch | isRet | (isBeq & flagsE) | (isBgt & flagsGT);
  assign target     = isRet ? op1 : branchTarget;
  assign nextPC     = taken ? target : e_pc + WIDTH'(4);
  assign isMiss     = e_valid & (taken != e_predTaken);
  assign condUpdate = e_valid & (isBeq | isBgt) & ~isUBranch & ~isRet;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= INIT_STATE;
    end else if (condUpdate) begin
      if (taken && bht[eIdx] != 2'd3)
        bht[eIdx] <= bht[eIdx] + 2'd1;
      else if (!taken && bht[eIdx] != 2'd0)
        bht[eIdx] <= bht[eIdx] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isBranchTaken   <= 1'b0;
      branchPC        <= '0;
      mispredict      <= 1'b0;
      redirectPC      <= '0;
      branchCount     <= '0;
      mispredictCount <= '0;
    end else begin
      mispredict <= isMiss;
      if (e_valid) begin
        isBranchTaken <= taken;
        branchPC      <= target;
        redirectPC    <= nextPC;
      end
      // Statistics stick at all-ones rather than wrapping.
      if (e_valid && anyBranch && !(&branchCount))
        branchCount <= branchCount + CNT_W'(1);
      if (isMiss && !(&mispredictCount))
        mispredictCount <= mispredictCount + CNT_W'(1);
    end
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction block for the SimpleRisc execute stage. Resolves `beq`/`bgt`/`b`/`call`/`ret` from flags and operands, as the single-cycle branch logic did. Also keeps a direct-mapped table of 2-bit saturating counters that gives fetch a taken/not-taken prediction. Outputs are registered, and the block raises a one-cycle mispredict pulse with the correct redirect PC and maintains saturating branch/mispredict statistics.

## Interface
- `WIDTH`, 32: PC/operand width (≥8).
- `BHT_DEPTH`, 16: table entries; power of 2, ≥2. `IDX = log2(BHT_DEPTH)`.
- `INIT_STATE`, 1: reset value of every counter (0 = strong NT, 1 = weak NT, 2 = weak T, 3 = strong T).
- `CNT_W`, 16: width of the statistics counters.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `f_pc` input `WIDTH`: fetch PC used for lookup.
- `f_predTaken` output 1: prediction for `f_pc`; combinational read of the table.
- `e_valid` input 1: execute-stage instruction valid this cycle.
- `e_pc` input `WIDTH`: PC of the executing instruction.
- `isBeq`, `isBgt`, `isUBranch`, `isRet` input 1 each: branch type decode.
- `flagsE`, `flagsGT` input 1 each: flags from the last `cmp`.
- `branchTarget` input `WIDTH`: immediate target.
- `op1` input `WIDTH`: return address (`ra`) for `ret`.
- `e_predTaken` input 1: prediction carried down the pipe with this instruction.
- `isBranchTaken` output 1: registered resolved direction.
- `branchPC` output `WIDTH`: registered resolved target. `op1` if `isRet`, else `branchTarget`.
- `mispredict` output 1: registered one-cycle pulse.
- `redirectPC` output `WIDTH`: registered correct next PC. `branchPC` if taken, else `e_pc + 4` (mod 2^WIDTH).
- `branchCount`, `mispredictCount` output `CNT_W` each: statistics.

## Operation
- Index = `pc[IDX+1:2]`, used for both lookup and update.
- `f_predTaken` = bit 1 of `bht[f_pc index]`.
- Resolve when `e_valid`:
  - `taken = isUBranch | isRet | (isBeq & flagsE) | (isBgt & flagsGT)`.
  - `isRet` selects `op1` even if other decode bits are set.
- Non-branch instruction (no is* bit set) with `e_valid`:
  - `taken = 0`.
  - `mispredict = e_predTaken` (corrects a false-taken fetch).
  - No table update; statistics counters do not increment.
- Mispredict when `e_valid & (taken != e_predTaken)`.
- Table update only for conditional branches: `e_valid & (isBeq | isBgt) & ~isUBranch & ~isRet`.
  - Taken: counter increments, saturating at 3.
  - Not taken: counter decrements, saturating at 0.
  - Unconditional branches and `ret` never update the table.
- `branchCount` increments on every `e_valid` cycle with any is* bit set.
- `mispredictCount` increments on every mispredict.
- Both statistics counters saturate at all-ones and never wrap.
- `e_valid = 0`: registered outputs hold their values, except `mispredict`, which is 0.

## Timing
- Lookup has zero latency. Resolution and update have one cycle of latency: inputs sampled at edge N appear on outputs and in the table after edge N.
- Same-cycle read and write of the same index: `f_predTaken` returns the pre-update value (no bypass).
- `mispredict` is high for exactly one cycle per offending instruction. Back-to-back mispredicts give back-to-back pulses.
- Reset, asynchronous, effective immediately:
  - All counters = `INIT_STATE`.
  - `isBranchTaken`, `mispredict` = 0.
  - `branchPC`, `redirectPC` = 0.
  - `branchCount`, `mispredictCount` = 0.
  - `f_predTaken` immediately reflects `INIT_STATE[1]`.
- Reset asserted mid-update: the update is lost. No partial writes.
- First edge after reset release behaves normally.

## Test plan
- Reset with `INIT_STATE=1`: any `f_pc` → `f_predTaken=0`; all outputs 0.
- `beq` at `e_pc=0x40`, `flagsE=1`, `e_predTaken=0`, `branchTarget=0x100` → next cycle `isBranchTaken=1`, `branchPC=0x100`, `redirectPC=0x100`, `mispredict=1`. `bht[0]` moves 1→2, so `f_pc=0x40` then predicts taken.
- `ret` with `op1=0x2C`, `e_predTaken=1` → `branchPC=0x2C`, `mispredict=0`. Table unchanged; `branchCount` +1.
- `bgt` at `e_pc=0x80`, `flagsGT=0`, `e_predTaken=1` → `isBranchTaken=0`, `redirectPC=0x84`, `mispredict=1`. Four repeats → counter saturates at 0.
- Same-index fetch lookup in the update cycle returns the old value. Pulse `rst` during an update → counter returns to `INIT_STATE` and no write lands.
- `CNT_W=4`: 20 mispredicting branches → `mispredictCount` holds at 15 and `branchCount` holds at 15.
